// File: rtl/uart_pkg.sv
// Shared types and legal-range constants for the configurable UART transmitter.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_W_MIN = 5;
  localparam int unsigned DATA_W_MAX = 9;
  localparam int unsigned OVS_MIN    = 4;
  localparam int unsigned OVS_MAX    = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_e;

  function automatic bit cfg_legal(input int unsigned data_w, input int unsigned ovs);
    return (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX) &&
           (ovs >= OVS_MIN) && (ovs <= OVS_MAX);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Request/status bundle between a frame source and the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DVSR_W = 11
);

  logic              tx_start;
  logic [DVSR_W-1:0] dvsr;
  logic [DATA_W-1:0] d_in;
  logic              stop2;
  logic              parity_en;
  logic              parity_odd;
  logic              tx_ready;
  logic              tx_done;
  logic              tx_out;

  modport master (
    output tx_start, dvsr, d_in, stop2, parity_en, parity_odd,
    input  tx_ready, tx_done, tx_out
  );

  modport slave (
    input  tx_start, dvsr, d_in, stop2, parity_en, parity_odd,
    output tx_ready, tx_done, tx_out
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one tick every dvsr+1 clocks, restartable by clear.
module uart_baud_gen #(
  parameter int unsigned DVSR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              tick_c
);

  logic [DVSR_W-1:0] cnt_q;

  assign tick_c = (cnt_q == dvsr);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DVSR_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: frame FSM, oversample/bit counters, shift register.
// Parity bit support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DVSR_W = 11,
  parameter int unsigned OVS    = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_cfg_if.slave   bus
);

  localparam int unsigned S_W = $clog2(OVS);
  localparam int unsigned N_W = $clog2(DATA_W);

  if (!cfg_legal(DATA_W, OVS)) begin : g_bad_cfg
    $error("uart_tx_cfg: DATA_W or OVS outside legal range");
  end

  tx_state_e         state_q, state_d;
  logic [S_W-1:0]    s_cnt_q, s_cnt_d;
  logic [N_W-1:0]    n_cnt_q, n_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DVSR_W-1:0] dvsr_q, dvsr_d;
  logic              stop2_q, stop2_d;
  logic              tx_out_q, tx_out_d;
  logic              tx_done_q, tx_done_d;
  logic              tx_ready_q, tx_ready_d;
  logic              tick_c, baud_clr_c, bit_end_c;
`ifdef UART_TX_PARITY_EN
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
`else
  logic              unused_parity;
  assign unused_parity = bus.parity_en ^ bus.parity_odd;
`endif

  uart_baud_gen #(.DVSR_W(DVSR_W)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (baud_clr_c),
    .dvsr   (dvsr_q),
    .tick_c (tick_c)
  );

  assign bit_end_c = tick_c && (s_cnt_q == S_W'(OVS - 1));

  // Next-state and next-output logic; tx_out is precomputed so it lines up with state
  always_comb begin
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    n_cnt_d    = n_cnt_q;
    shreg_d    = shreg_q;
    dvsr_d     = dvsr_q;
    stop2_d    = stop2_q;
    tx_out_d   = tx_out_q;
    tx_done_d  = 1'b0;
    baud_clr_c = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif

    if ((state_q != IDLE) && tick_c) begin
      s_cnt_d = bit_end_c ? '0 : s_cnt_q + S_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_out_d = 1'b1;
        if (bus.tx_start) begin
          shreg_d    = bus.d_in;
          dvsr_d     = bus.dvsr;
          stop2_d    = bus.stop2;
`ifdef UART_TX_PARITY_EN
          par_en_d   = bus.parity_en;
          par_bit_d  = (^bus.d_in) ^ bus.parity_odd;
`endif
          s_cnt_d    = '0;
          n_cnt_d    = '0;
          baud_clr_c = 1'b1;
          tx_out_d   = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          state_d  = DATA;
          tx_out_d = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end_c) begin
          shreg_d = shreg_q >> 1;
          if (n_cnt_q == N_W'(DATA_W - 1)) begin
            n_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d  = PARITY;
              tx_out_d = par_bit_q;
            end else
`endif
            begin
              state_d  = STOP;
              tx_out_d = 1'b1;
            end
          end else begin
            n_cnt_d  = n_cnt_q + N_W'(1);
            tx_out_d = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_c) begin
          state_d  = STOP;
          tx_out_d = 1'b1;
        end
      end
`endif
      STOP: begin
        // n_cnt counts completed stop bits when two are requested
        if (bit_end_c) begin
          if (stop2_q && (n_cnt_q == '0)) begin
            n_cnt_d = N_W'(1);
          end else begin
            n_cnt_d   = '0;
            state_d   = IDLE;
            tx_done_d = 1'b1;
            tx_out_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s_cnt_q    <= '0;
      n_cnt_q    <= '0;
      shreg_q    <= '0;
      dvsr_q     <= '0;
      stop2_q    <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_done_q  <= 1'b0;
      tx_ready_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      n_cnt_q    <= n_cnt_d;
      shreg_q    <= shreg_d;
      dvsr_q     <= dvsr_d;
      stop2_q    <= stop2_d;
      tx_out_q   <= tx_out_d;
      tx_done_q  <= tx_done_d;
      tx_ready_q <= tx_ready_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

  assign bus.tx_out   = tx_out_q;
  assign bus.tx_done  = tx_done_q;
  assign bus.tx_ready = tx_ready_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg (DATA_W=8, OVS=16).
// Expected frames are hand-written bit vectors, index 0 = first bit on the line.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_tx_cfg_if #(.DATA_W(8), .DVSR_W(11)) bus ();

  uart_tx_cfg #(.DATA_W(8), .DVSR_W(11), .OVS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // 0xAA, 8N1
  localparam logic [15:0] F_AA    = 16'h0354;
  // 0x55, 8N1
  localparam logic [15:0] F_55    = 16'h02AA;
  // 0xC3, 8N1
  localparam logic [15:0] F_C3    = 16'h0386;
`ifdef UART_TX_PARITY_EN
  localparam logic [15:0] F_01_E2 = 16'h0E02;  // 0x01, even parity=1, 2 stop
  localparam int          N_01_E2 = 12;
  localparam logic [15:0] F_01_O1 = 16'h0402;  // 0x01, odd parity=0, 1 stop
  localparam int          N_01_O1 = 11;
`else
  localparam logic [15:0] F_01_E2 = 16'h0602;  // no parity bit, 2 stop
  localparam int          N_01_E2 = 11;
  localparam logic [15:0] F_01_O1 = 16'h0202;  // no parity bit, 1 stop
  localparam int          N_01_O1 = 10;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Samples every clock of a frame starting the cycle after accept, then the tx_done cycle.
  task automatic expect_frame(input string tag, input logic [15:0] bits, input int nbits,
                              input int bitlen, input bit hold, input int pulse_at,
                              input int change_at);
    int bit_err  = 0;
    int done_err = 0;
    int rdy_err  = 0;
    int idx      = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < bitlen; c++) begin
        @(negedge clk);
        if (bus.tx_out !== bits[b]) bit_err++;
        if (bus.tx_done !== 1'b0)   done_err++;
        if (bus.tx_ready !== 1'b0)  rdy_err++;
        if (idx == 0 && !hold) bus.tx_start = 1'b0;
        if (idx == pulse_at) bus.tx_start = 1'b1;
        else if (pulse_at > 0 && idx == pulse_at + 1) bus.tx_start = 1'b0;
        if (idx == change_at) begin
          bus.d_in = 8'h55;
          bus.dvsr = 11'd5;
        end
        idx++;
      end
    end
    check({tag, "_bits"}, 32'(bit_err), 32'd0);
    check({tag, "_early_done"}, 32'(done_err), 32'd0);
    check({tag, "_busy_ready"}, 32'(rdy_err), 32'd0);
    @(negedge clk);
    check({tag, "_done"}, 32'(bus.tx_done), 32'd1);
    check({tag, "_done_ready"}, 32'(bus.tx_ready), 32'd1);
    check({tag, "_done_line"}, 32'(bus.tx_out), 32'd1);
  endtask

  task automatic send(input string tag, input logic [7:0] data, input logic [10:0] dv,
                      input logic s2, input logic pe, input logic po,
                      input logic [15:0] bits, input int nbits, input int bitlen,
                      input bit hold, input int pulse_at, input int change_at);
    bus.d_in       = data;
    bus.dvsr       = dv;
    bus.stop2      = s2;
    bus.parity_en  = pe;
    bus.parity_odd = po;
    bus.tx_start   = 1'b1;
    expect_frame(tag, bits, nbits, bitlen, hold, pulse_at, change_at);
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check({tag, "_idle_done"}, 32'(bus.tx_done), 32'd0);
    check({tag, "_idle_line"}, 32'(bus.tx_out), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    bus.tx_start   = 1'b1;
    bus.d_in       = 8'h00;
    bus.dvsr       = 11'd2;
    bus.stop2      = 1'b0;
    bus.parity_en  = 1'b0;
    bus.parity_odd = 1'b0;

    // Reset with tx_start asserted must accept nothing
    repeat (3) @(negedge clk);
    check("rst_line", 32'(bus.tx_out), 32'd1);
    check("rst_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_done", 32'(bus.tx_done), 32'd0);
    rst = 1'b0;
    bus.tx_start = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_line", 32'(bus.tx_out), 32'd1);
    check("post_rst_ready", 32'(bus.tx_ready), 32'd1);

    send("aa_8n1", 8'hAA, 11'd2, 1'b0, 1'b0, 1'b0, F_AA, 10, 48, 1'b0, -1, -1);
    expect_idle("aa_8n1");

    send("p01_even_2s", 8'h01, 11'd2, 1'b1, 1'b1, 1'b0, F_01_E2, N_01_E2, 48, 1'b0, -1, -1);
    expect_idle("p01_even_2s");

    // Mid-frame tx_start pulse must be ignored
    send("p01_odd_pulse", 8'h01, 11'd2, 1'b0, 1'b1, 1'b1, F_01_O1, N_01_O1, 48, 1'b0, 200, -1);
    expect_idle("p01_odd_pulse");

    // d_in/dvsr change mid-frame only affects the next frame
    send("aa_chg", 8'hAA, 11'd2, 1'b0, 1'b0, 1'b0, F_AA, 10, 48, 1'b0, -1, 100);
    expect_idle("aa_chg");
    send("x55_dv5", 8'h55, 11'd5, 1'b0, 1'b0, 1'b0, F_55, 10, 96, 1'b0, -1, -1);
    expect_idle("x55_dv5");

    // tx_start held: second start bit right after a single idle cycle
    send("b2b_first", 8'hAA, 11'd2, 1'b0, 1'b0, 1'b0, F_AA, 10, 48, 1'b1, -1, -1);
    expect_frame("b2b_second", F_AA, 10, 48, 1'b0, -1, -1);
    expect_idle("b2b_second");

    // Reset during DATA bit 3 (line low there for 0x55)
    bus.d_in     = 8'h55;
    bus.dvsr     = 11'd2;
    bus.tx_start = 1'b1;
    bad = 0;
    for (int i = 0; i < 212; i++) begin
      @(negedge clk);
      if (bus.tx_out !== F_55[i / 48]) bad++;
      if (i == 0) bus.tx_start = 1'b0;
    end
    check("abort_prefix", 32'(bad), 32'd0);
    check("abort_line_low", 32'(bus.tx_out), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_line", 32'(bus.tx_out), 32'd1);
    check("abort_ready", 32'(bus.tx_ready), 32'd1);
    check("abort_done", 32'(bus.tx_done), 32'd0);
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.tx_done !== 1'b0 || bus.tx_out !== 1'b1 || bus.tx_ready !== 1'b1) bad++;
    end
    check("abort_quiet", 32'(bad), 32'd0);

    // dvsr=0: one tick per clock, 16-clock bits
    send("c3_dv0", 8'hC3, 11'd0, 1'b0, 1'b0, 1'b0, F_C3, 10, 16, 1'b0, -1, -1);
    expect_idle("c3_dv0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
